// File: rtl/axis_pack_pkg.sv
// Shared constants, FSM states and beat-geometry helpers for the multi-channel AXIS packer.
// Latency: none (package only).
// Backpressure: n/a. Honours AXIS_PACK_HDR_BEAT_EN (dedicated header beat) when defined.
package axis_pack_pkg;

  localparam int HDR_WIDTH   = 16;
  localparam int HDR_SEQ_LSB = 0;
  localparam int HDR_SEQ_W   = 8;
  localparam int HDR_CH_LSB  = 8;
  localparam int HDR_CH_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_e;

  // Beats per packet for a record of dw bits on an aw-bit stream.
  function automatic int num_beats(input int dw, input int aw);
`ifdef AXIS_PACK_HDR_BEAT_EN
    return 1 + (dw + aw - 1) / aw;
`else
    return (dw + HDR_WIDTH + aw - 1) / aw;
`endif
  endfunction

  // Bit position of the record's LSB inside the serialised packet.
  function automatic int rec_offset(input int aw);
`ifdef AXIS_PACK_HDR_BEAT_EN
    return aw;
`else
    return HDR_WIDTH;
`endif
  endfunction

  // Number of meaningful bits carried by the final beat.
  function automatic int last_bits(input int dw, input int aw);
    int nb;
    nb = num_beats(dw, aw);
`ifdef AXIS_PACK_HDR_BEAT_EN
    return dw - (nb - 2) * aw;
`else
    return dw + HDR_WIDTH - (nb - 1) * aw;
`endif
  endfunction

  // Number of tkeep bits set on the final beat.
  function automatic int last_keep_bytes(input int dw, input int aw);
    return (last_bits(dw, aw) + 7) / 8;
  endfunction

  function automatic logic [HDR_WIDTH-1:0] make_hdr(input logic [HDR_CH_W-1:0] ch,
                                                    input logic [HDR_SEQ_W-1:0] seq);
    logic [HDR_WIDTH-1:0] h;
    h = '0;
    h[HDR_CH_LSB +: HDR_CH_W]   = ch;
    h[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
    return h;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after the last granted channel.
// Latency: grant is combinational; last-grant register updates on the clock after upd.
// Backpressure: none; requester holds req until granted (caller gates req when busy).
module axis_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              upd,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [CW-1:0]     gnt_idx,
  output logic              gnt_vld
);

  logic [CW-1:0] last_q, last_d;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!gnt_vld && req[(int'(last_q) + i) % NUM_CH]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'((int'(last_q) + i) % NUM_CH);
        gnt_oh[(int'(last_q) + i) % NUM_CH] = 1'b1;
      end
    end
  end

  // Remember the winner when the caller commits the grant.
  always_comb begin
    last_d = last_q;
    if (upd && gnt_vld) last_d = gnt_idx;
  end

  // Reset to the highest channel so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= CW'(NUM_CH - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/axis_mc_data_packer.sv
// Multi-channel record packer: round-robin picks a channel, prefixes {ch,seq} header, streams beats.
// Latency: accept in IDLE at cycle t -> beat 0 valid at t+1; one beat per cycle, one idle gap per packet.
// Backpressure: beats held stable while tvalid & !tready; producers see ch_ready only in IDLE.
// Optional: AXIS_PACK_HDR_BEAT_EN puts the header in its own beat 0.
module axis_mc_data_packer
  import axis_pack_pkg::*;
#(
  parameter int DATA_WIDTH      = 4064,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int NUM_CH          = 4
) (
  input  logic                         m_axis_c2h_aclk,
  input  logic                         m_axis_c2h_aresetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_c2h_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_c2h_tkeep,
  output logic                         m_axis_c2h_tlast,
  output logic                         m_axis_c2h_tvalid,
  input  logic                         m_axis_c2h_tready,
  output logic [1:0]                   sstate,
  output logic [3:0]                   cur_ch
);

  localparam int AW         = AXIS_DATA_WIDTH;
  localparam int KW         = AW / 8;
  localparam int NB         = num_beats(DATA_WIDTH, AW);
  localparam int SR_W       = NB * AW;
  localparam int REC_OFF    = rec_offset(AW);
  localparam int LAST_BYTES = last_keep_bytes(DATA_WIDTH, AW);
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW         = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] FULL_KEEP = '1;
  localparam logic [KW-1:0] LAST_KEEP = FULL_KEEP >> (KW - LAST_BYTES);
  localparam logic [BW-1:0] LAST_IDX  = BW'(NB - 1);

  state_e          state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [AW-1:0]   tdata_q, tdata_d;
  logic [KW-1:0]   tkeep_q, tkeep_d;
  logic            tlast_q, tlast_d;
  logic            tvalid_q, tvalid_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [7:0]      seq_q [NUM_CH];
  logic [7:0]      seq_d [NUM_CH];

  logic [NUM_CH-1:0] arb_req;
  logic [NUM_CH-1:0] gnt_oh;
  logic [CW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [SR_W-1:0]   load_vec;

  // Producers are only considered while idle; requests during SEND are ignored.
  assign arb_req = ch_valid & {NUM_CH{state_q == IDLE}};

  axis_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_arb (
    .clk     (m_axis_c2h_aclk),
    .rst_n   (m_axis_c2h_aresetn),
    .req     (arb_req),
    .upd     (gnt_vld),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign ch_ready          = gnt_oh;
  assign m_axis_c2h_tdata  = tdata_q;
  assign m_axis_c2h_tkeep  = tkeep_q;
  assign m_axis_c2h_tlast  = tlast_q;
  assign m_axis_c2h_tvalid = tvalid_q;
  assign sstate            = state_q;
  assign cur_ch            = 4'(cur_ch_q);

  // Whole packet image of the granted channel: header at the bottom, record above, zero padding on top.
  always_comb begin
    load_vec = '0;
    load_vec[HDR_WIDTH-1:0] = make_hdr(4'(gnt_idx), seq_q[gnt_idx]);
    load_vec[REC_OFF +: DATA_WIDTH] = ch_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Packet sequencing: load on grant, advance one beat per accepted transfer, close out on tlast.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    cur_ch_d = cur_ch_q;
    beat_d   = beat_q;
    seq_d    = seq_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          tdata_d  = load_vec[AW-1:0];
          sr_d     = load_vec >> AW;
          tlast_d  = (NB == 1);
          tkeep_d  = (NB == 1) ? LAST_KEEP : FULL_KEEP;
          tvalid_d = 1'b1;
          cur_ch_d = gnt_idx;
          beat_d   = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (m_axis_c2h_tready) begin
          if (tlast_q) begin
            tvalid_d         = 1'b0;
            tlast_d          = 1'b0;
            tdata_d          = '0;
            tkeep_d          = '0;
            seq_d[cur_ch_q]  = seq_q[cur_ch_q] + 8'd1;
            state_d          = IDLE;
          end else begin
            tdata_d = sr_q[AW-1:0];
            sr_d    = sr_q >> AW;
            beat_d  = beat_q + 1'b1;
            tlast_d = (beat_d == LAST_IDX);
            tkeep_d = (beat_d == LAST_IDX) ? LAST_KEEP : FULL_KEEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and all stream outputs are registered; reset truncates any packet in flight.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      cur_ch_q <= '0;
      beat_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) seq_q[i] <= 8'd0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      cur_ch_q <= cur_ch_d;
      beat_q   <= beat_d;
      for (int i = 0; i < NUM_CH; i++) seq_q[i] <= seq_d[i];
    end
  end

endmodule
